// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: the NOP substituted for faulted fetches,
// the fault encoding, the packed response record and a fault classifier.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_MISALIGNED   = 2'd1,
    FAULT_OUT_OF_RANGE = 2'd2
  } fetch_fault_t;

  typedef struct packed {
    logic [31:0]  instr;
    logic [31:0]  addr;
    fetch_fault_t fault;
  } fetch_resp_t;

  // Misalignment is checked first so it wins over out-of-range.
  function automatic fetch_fault_t classify(input logic [31:0] addr,
                                            input int unsigned depth_words);
    if (addr[1:0] != 2'b00)
      return FAULT_MISALIGNED;
    if ({2'b00, addr[31:2]} >= depth_words)
      return FAULT_OUT_OF_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Response FIFO for the instruction-memory responder.
// Ports: clk, rst_n (async active-low); push/push_data write the tail;
// pop removes the head (ignored when empty); flush empties the FIFO
// synchronously; count is the occupancy, head the oldest entry (zero when
// empty) and empty flags no entries.
module imem_resp_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fetch_resp_t                   push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output fetch_resp_t                   head,
  output logic                          empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_resp_t   store [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && ((count < CW'(FIFO_DEPTH)) || do_pop);
    head    = empty ? '0 : store[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch per cycle, reads the
// synchronous instruction RAM and returns {instr, addr, fault} through a
// response FIFO with 2-cycle latency.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_addr fetch
// request handshake; resp_valid/resp_ready/resp_instr/resp_addr/resp_fault
// response handshake; flush discards in-flight and buffered work;
// wr_en/wr_addr/wr_data program-load write port.
module imem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic [1:0]  resp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   rd_data;
  logic [31:0]   s1_addr;
  fetch_fault_t  s1_fault;
  fetch_fault_t  req_fault;
  logic          inflight;
  logic          accept;
  logic          pop;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_resp_t   head;
  fetch_resp_t   push_data;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};

  // Occupancy counts the in-flight slot and credits a same-cycle pop so
  // that a full-rate stream never stalls at FIFO_DEPTH = 2.
  always_comb begin
    pop       = !fifo_empty && resp_ready;
    occupancy = OW'(fifo_count) + OW'(inflight) - OW'(pop);
    req_ready = !flush && (occupancy < OW'(FIFO_DEPTH));
    accept    = req_valid && req_ready;
    req_fault = classify(req_addr, DEPTH_WORDS);
  end

  // Non-blocking read and write in the same block give read-first
  // behaviour on a same-address collision. The read index is masked to
  // the array width, so faulted requests never leave the array.
  always_ff @(posedge clk) begin
    if (wr_en)
      ram[wr_addr[AW+1:2]] <= wr_data;
    if (accept)
      rd_data <= ram[req_addr[AW+1:2]];
  end

  // accept is forced low during flush, so inflight clears on a flush edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      s1_addr  <= '0;
      s1_fault <= FAULT_NONE;
    end else begin
      inflight <= accept;
      if (accept) begin
        s1_addr  <= req_addr;
        s1_fault <= req_fault;
      end
    end
  end

  always_comb begin
    push_data.instr = (s1_fault == FAULT_NONE) ? rd_data : NOP_INSTR;
    push_data.addr  = s1_addr;
    push_data.fault = s1_fault;
  end

  imem_resp_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign resp_valid = !fifo_empty;
  assign resp_instr = head.instr;
  assign resp_addr  = head.addr;
  assign resp_fault = head.fault;

endmodule
